// File: rtl/rob_fifo_pkg.sv
// Shared widths and the entry layout for the reorder-buffer response FIFOs.
// Imported by rob_fifo to derive its default DATA_WIDTH and DEPTH.
package rob_fifo_pkg;

    localparam int AXI_DATA_WIDTH = 512;
    localparam int AXI_ID_WIDTH   = 8;
    localparam int TID_WIDTH      = AXI_ID_WIDTH;
    localparam int FIFO_SIZE      = 16;

    // Entry layout as stored by the hit and miss response FIFOs
    typedef struct packed {
        logic [TID_WIDTH-1:0]      tid;
        logic [AXI_DATA_WIDTH-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/rob_fifo.sv
// Single-clock show-ahead FIFO holding {tid, data} response entries.
// Optional occupancy output count_o is built when FIFO_COUNT_EN is defined.
module rob_fifo
    import rob_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = TID_WIDTH + AXI_DATA_WIDTH,
    parameter int DEPTH      = FIFO_SIZE,
    parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  full_o,
    input  logic                  write_en_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    output logic                  empty_o,
    input  logic                  read_en_i,
`ifdef FIFO_COUNT_EN
    output logic [PTR_WIDTH:0]    count_o,
`endif
    output logic [DATA_WIDTH-1:0] read_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH:0]    wp_q, wp_d;
    logic [PTR_WIDTH:0]    rp_q, rp_d;
    logic                  push_ok;
    logic                  pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign empty_o = (wp_q == rp_q);
    assign full_o  = (wp_q[PTR_WIDTH] != rp_q[PTR_WIDTH]) &&
                     (wp_q[PTR_WIDTH-1:0] == rp_q[PTR_WIDTH-1:0]);

    assign push_ok = write_en_i && !full_o;
    assign pop_ok  = read_en_i && !empty_o;

    assign wp_d = wp_q + {{PTR_WIDTH{1'b0}}, push_ok};
    assign rp_d = rp_q + {{PTR_WIDTH{1'b0}}, pop_ok};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    // Storage is left uninitialised; empty_o masks stale contents on the head
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wp_q[PTR_WIDTH-1:0]] <= write_data_i;
        end
    end

    assign read_data_o = empty_o ? '0 : mem_q[rp_q[PTR_WIDTH-1:0]];

`ifdef FIFO_COUNT_EN
    assign count_o = wp_q - rp_q;
`endif

endmodule

// File: tb/tb_rob_fifo.sv
// Self-checking bench for rob_fifo at DEPTH=4, DATA_WIDTH=8: directed table,
// hand-written corner sequences, then random traffic against a queue model.
module tb_rob_fifo;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          run = 1'b0;
    logic          rst = 1'b0;
    logic          full_o, empty_o;
    logic          write_en_i = 1'b0;
    logic          read_en_i  = 1'b0;
    logic [DW-1:0] write_data_i = '0;
    logic [DW-1:0] read_data_o;
`ifdef FIFO_COUNT_EN
    logic [PW:0]   count_o;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    rob_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk          (clk),
        .rst          (rst),
        .full_o       (full_o),
        .write_en_i   (write_en_i),
        .write_data_i (write_data_i),
        .empty_o      (empty_o),
        .read_en_i    (read_en_i),
`ifdef FIFO_COUNT_EN
        .count_o      (count_o),
`endif
        .read_data_o  (read_data_o)
    );

    initial forever begin
        #5;
        if (run) clk = ~clk;
    end

    typedef struct {
        logic          we;
        logic          re;
        logic [DW-1:0] wd;
        logic          e_empty;
        logic          e_full;
        logic [DW-1:0] e_rd;
        int            e_cnt;
    } vec_t;

    vec_t vt[22];

    logic [DW-1:0] mq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_state(input string nm, input logic e, input logic f,
                             input logic [DW-1:0] rd, input int cnt);
        chk({nm, ".empty"}, 32'(empty_o), 32'(e));
        chk({nm, ".full"},  32'(full_o),  32'(f));
        chk({nm, ".head"},  32'(read_data_o), 32'(rd));
`ifdef FIFO_COUNT_EN
        chk({nm, ".count"}, 32'(count_o), 32'(cnt));
`else
        if (cnt < 0) $display("unexpected negative count %0d", cnt);
`endif
    endtask

    // One clock: drive at negedge, sample 1 time unit after the rising edge
    task automatic step(input logic we, input logic re, input logic [DW-1:0] wd);
        @(negedge clk);
        write_en_i   = we;
        read_en_i    = re;
        write_data_i = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        write_en_i = 1'b0;
        read_en_i  = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        mq.delete();
    endtask

    // Reference: a bounded queue updated by the accept rules
    task automatic model(input logic we, input logic re, input logic [DW-1:0] wd);
        bit was_full  = (mq.size() == DP);
        bit was_empty = (mq.size() == 0);
        if (re && !was_empty) void'(mq.pop_front());
        if (we && !was_full) mq.push_back(wd);
    endtask

    function automatic logic [DW-1:0] m_head();
        return (mq.size() == 0) ? '0 : mq[0];
    endfunction

    initial begin
        // {we, re, wd, empty, full, head, count} after the edge
        vt[0]  = '{1, 0, 8'hA1, 0, 0, 8'hA1, 1};
        vt[1]  = '{0, 1, 8'h00, 1, 0, 8'h00, 0};
        vt[2]  = '{1, 0, 8'h11, 0, 0, 8'h11, 1};
        vt[3]  = '{1, 0, 8'h22, 0, 0, 8'h11, 2};
        vt[4]  = '{1, 0, 8'h33, 0, 0, 8'h11, 3};
        vt[5]  = '{1, 0, 8'h44, 0, 1, 8'h11, 4};
        vt[6]  = '{1, 0, 8'h55, 0, 1, 8'h11, 4};
        vt[7]  = '{0, 1, 8'h00, 0, 0, 8'h22, 3};
        vt[8]  = '{0, 1, 8'h00, 0, 0, 8'h33, 2};
        vt[9]  = '{0, 1, 8'h00, 0, 0, 8'h44, 1};
        vt[10] = '{0, 1, 8'h00, 1, 0, 8'h00, 0};
        vt[11] = '{0, 1, 8'h00, 1, 0, 8'h00, 0};
        vt[12] = '{1, 0, 8'h11, 0, 0, 8'h11, 1};
        vt[13] = '{1, 0, 8'h22, 0, 0, 8'h11, 2};
        vt[14] = '{1, 0, 8'h33, 0, 0, 8'h11, 3};
        vt[15] = '{1, 0, 8'h44, 0, 1, 8'h11, 4};
        vt[16] = '{1, 1, 8'h66, 0, 0, 8'h22, 3};
        vt[17] = '{0, 1, 8'h00, 0, 0, 8'h33, 2};
        vt[18] = '{0, 1, 8'h00, 0, 0, 8'h44, 1};
        vt[19] = '{0, 1, 8'h00, 1, 0, 8'h00, 0};
        vt[20] = '{1, 1, 8'h77, 0, 0, 8'h77, 1};
        vt[21] = '{0, 1, 8'h00, 1, 0, 8'h00, 0};

        // Reset asserted with the clock stopped
        #1 rst = 1'b1;
        #4 chk_state("rst_held", 1, 0, 8'h00, 0);
        rst = 1'b0;
        #4 chk_state("rst_rel", 1, 0, 8'h00, 0);
        run = 1'b1;

        foreach (vt[i]) begin
            step(vt[i].we, vt[i].re, vt[i].wd);
            chk_state($sformatf("vec%0d", i), vt[i].e_empty, vt[i].e_full,
                      vt[i].e_rd, vt[i].e_cnt);
        end

        // Streaming: one resident entry, push and pop every cycle across wraps
        step(1, 0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 8'(i + 1));
            chk_state($sformatf("stream%0d", i), 0, 0, 8'(i + 1), 1);
        end
        step(0, 1, 8'h00);
        chk_state("stream_drain", 1, 0, 8'h00, 0);

        // Asynchronous reset between edges discards three entries
        step(1, 0, 8'hC1);
        step(1, 0, 8'hC2);
        step(1, 0, 8'hC3);
        chk_state("pre_arst", 0, 0, 8'hC1, 3);
        @(negedge clk);
        write_en_i = 1'b0;
        rst = 1'b1;
        #1 chk_state("arst_now", 1, 0, 8'h00, 0);
        #1 rst = 1'b0;
        step(1, 0, 8'h99);
        chk_state("post_arst", 0, 0, 8'h99, 1);
        step(0, 0, 8'h00);
        chk_state("post_arst_hold", 0, 0, 8'h99, 1);

        // Random traffic against the queue model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic          we, re;
            logic [DW-1:0] wd;
            int            bias;
            bias = (i / 50) % 3;
            we = ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)));
            re = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)));
            wd = 8'($urandom);
            step(we, re, wd);
            model(we, re, wd);
            chk_state($sformatf("rnd%0d", i), mq.size() == 0, mq.size() == DP,
                      m_head(), mq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
